// File: rtl/stopwatch_ctl.sv
// Stopwatch run-control: debounces start/lap/clear buttons, sequences the
// IDLE/RUN/LAP/PAUSE FSM and drives timer gating, lap freeze and pause blink.
module stopwatch_ctl #(
    parameter int DEB_CYCLES = 20000,
    parameter int DEB_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_sec,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clr,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       lap_latch,
    output logic       disp_sel,
    output logic       run_led,
    output logic       pause_blink,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

    // Button bit order: 0 = start, 1 = lap, 2 = clear.
    logic [2:0]       btn_raw_s;
    logic [2:0]       sync1_r;
    logic [2:0]       sync2_r;
    logic [2:0]       deb_r;
    logic [2:0]       deb_q_r;
    logic [DEB_W-1:0] deb_cnt_r [3];
    logic [2:0]       press_s;

    state_t state_r;
    state_t next_state_s;
    logic   cnt_clr_s;
    logic   lap_latch_s;
    logic   blink_s;
    logic   cnt_clr_r;
    logic   lap_latch_r;
    logic   disp_sel_r;
    logic   run_led_r;
    logic   pause_blink_r;

    assign btn_raw_s = {btn_clr, btn_lap, btn_start};
    assign press_s   = deb_r & ~deb_q_r;

    // Synchronize raw buttons and debounce each one independently.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            deb_r   <= 3'b000;
            deb_q_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_r[i] <= {DEB_W{1'b0}};
            end
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            deb_q_r <= deb_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= {DEB_W{1'b0}};
                end else if (deb_cnt_r[i] == DEB_MAX) begin
                    deb_r[i]     <= sync2_r[i];
                    deb_cnt_r[i] <= {DEB_W{1'b0}};
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DEB_W'(1);
                end
            end
        end
    end

    // Next-state and pulse decode; only the highest-priority event (clr > start > lap) is considered.
    always_comb begin
        next_state_s = state_r;
        cnt_clr_s    = 1'b0;
        lap_latch_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (press_s[2]) begin
                    cnt_clr_s = 1'b1;
                end else if (press_s[0]) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (press_s[2]) begin
                    next_state_s = ST_RUN;
                end else if (press_s[0]) begin
                    next_state_s = ST_PAUSE;
                end else if (press_s[1]) begin
                    next_state_s = ST_LAP;
                    lap_latch_s  = 1'b1;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_LAP: begin
                if (press_s[2]) begin
                    next_state_s = ST_RUN;
                end else if (press_s[0]) begin
                    next_state_s = ST_PAUSE;
                end else if (press_s[1]) begin
                    lap_latch_s = 1'b1;
                end else begin
                    next_state_s = ST_LAP;
                end
            end
            ST_PAUSE: begin
                if (press_s[2]) begin
                    next_state_s = ST_IDLE;
                    cnt_clr_s    = 1'b1;
                end else if (press_s[0]) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_PAUSE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Blink restarts at 0 on PAUSE entry and toggles only on ticks seen while already paused.
    always_comb begin
        blink_s = 1'b0;
        if (next_state_s != ST_PAUSE) begin
            blink_s = 1'b0;
        end else if ((state_r == ST_PAUSE) && one_sec) begin
            blink_s = ~pause_blink_r;
        end else if (state_r == ST_PAUSE) begin
            blink_s = pause_blink_r;
        end else begin
            blink_s = 1'b0;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_clr_r     <= 1'b0;
            lap_latch_r   <= 1'b0;
            disp_sel_r    <= 1'b0;
            run_led_r     <= 1'b0;
            pause_blink_r <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            cnt_clr_r     <= cnt_clr_s;
            lap_latch_r   <= lap_latch_s;
            disp_sel_r    <= (next_state_s == ST_LAP);
            run_led_r     <= (next_state_s == ST_RUN) || (next_state_s == ST_LAP);
            pause_blink_r <= blink_s;
        end
    end

    assign cnt_en      = one_sec && ((state_r == ST_RUN) || (state_r == ST_LAP));
    assign cnt_clr     = cnt_clr_r;
    assign lap_latch   = lap_latch_r;
    assign disp_sel    = disp_sel_r;
    assign run_led     = run_led_r;
    assign pause_blink = pause_blink_r;
    assign state       = state_r;

endmodule

// File: tb/tb_stopwatch_ctl.sv
// Directed bench for stopwatch_ctl with DEB_CYCLES=4 (press-to-state latency 7 edges).
module tb_stopwatch_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic       one_sec;
    logic       btn_start;
    logic       btn_lap;
    logic       btn_clr;
    logic       cnt_en;
    logic       cnt_clr;
    logic       lap_latch;
    logic       disp_sel;
    logic       run_led;
    logic       pause_blink;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    stopwatch_ctl #(.DEB_CYCLES(4), .DEB_W(16)) dut (
        .clk(clk), .reset(reset), .one_sec(one_sec),
        .btn_start(btn_start), .btn_lap(btn_lap), .btn_clr(btn_clr),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .lap_latch(lap_latch),
        .disp_sel(disp_sel), .run_led(run_led), .pause_blink(pause_blink),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the button mask {clr,lap,start} and advance to one edge before the state update.
    task automatic press_hold(input logic [2:0] m);
        {btn_clr, btn_lap, btn_start} = m;
        repeat (6) tick();
    endtask

    task automatic release_all();
        {btn_clr, btn_lap, btn_start} = 3'b000;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; one_sec = 1'b0;
        {btn_clr, btn_lap, btn_start} = 3'b000;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if ({state, cnt_clr, lap_latch, disp_sel, run_led, pause_blink, cnt_en} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000000",
                     {state, cnt_clr, lap_latch, disp_sel, run_led, pause_blink, cnt_en});
        end
    endtask

    task automatic test_debounce();
        int bad;
        btn_start = 1'b1;
        repeat (3) tick();
        btn_start = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (state !== 2'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL glitch_reject got state=%0d exp=0", state);
        end
        press_hold(3'b001);
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL press_edge6 got=%0d exp=0", state);
        end
        tick();
        checks++;
        if (state !== 2'd1 || run_led !== 1'b1) begin
            failures++;
            $display("FAIL press_edge7 got state=%0d led=%b exp state=1 led=1", state, run_led);
        end
        repeat (3) tick();
        release_all();
    endtask

    task automatic test_count_gate();
        int bad;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            repeat (9) begin
                tick();
                if (cnt_en !== 1'b0) bad++;
            end
            one_sec = 1'b1;
            #1;
            if (cnt_en !== 1'b1) bad++;
            tick();
            one_sec = 1'b0;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL run_cnt_en_mirror got %0d bad samples exp 0", bad);
        end
        press_hold(3'b001);
        tick();
        checks++;
        if (state !== 2'd3 || run_led !== 1'b0 || pause_blink !== 1'b0) begin
            failures++;
            $display("FAIL enter_pause got state=%0d led=%b blink=%b exp 3/0/0", state, run_led, pause_blink);
        end
        release_all();
        one_sec = 1'b1;
        #1;
        checks++;
        if (cnt_en !== 1'b0) begin
            failures++;
            $display("FAIL pause_cnt_en got=%b exp=0", cnt_en);
        end
        tick();
        one_sec = 1'b0;
        press_hold(3'b001);
        tick();
        checks++;
        if (state !== 2'd1 || pause_blink !== 1'b0) begin
            failures++;
            $display("FAIL pause_to_run got state=%0d blink=%b exp 1/0", state, pause_blink);
        end
        release_all();
    endtask

    task automatic test_blink();
        logic [2:0] seen;
        logic [2:0] exp_seq;
        press_hold(3'b001);
        tick();
        release_all();
        checks++;
        if (state !== 2'd3 || pause_blink !== 1'b0) begin
            failures++;
            $display("FAIL blink_entry got state=%0d blink=%b exp 3/0", state, pause_blink);
        end
        exp_seq = 3'b101;
        seen = 3'b000;
        for (int k = 0; k < 3; k++) begin
            one_sec = 1'b1;
            tick();
            one_sec = 1'b0;
            seen[2-k] = pause_blink;
            repeat (3) tick();
        end
        checks++;
        if (seen !== exp_seq) begin
            failures++;
            $display("FAIL blink_seq got=%b exp=%b", seen, exp_seq);
        end
    endtask

    task automatic test_clear();
        press_hold(3'b100);
        tick();
        checks++;
        if (state !== 2'd0 || cnt_clr !== 1'b1 || pause_blink !== 1'b0) begin
            failures++;
            $display("FAIL clr_pause got state=%0d clr=%b blink=%b exp 0/1/0", state, cnt_clr, pause_blink);
        end
        tick();
        checks++;
        if (cnt_clr !== 1'b0) begin
            failures++;
            $display("FAIL clr_single got=%b exp=0", cnt_clr);
        end
        release_all();
        press_hold(3'b001);
        tick();
        release_all();
        press_hold(3'b100);
        tick();
        checks++;
        if (state !== 2'd1 || cnt_clr !== 1'b0) begin
            failures++;
            $display("FAIL clr_in_run got state=%0d clr=%b exp 1/0", state, cnt_clr);
        end
        release_all();
    endtask

    task automatic test_lap();
        press_hold(3'b010);
        tick();
        checks++;
        if (state !== 2'd2 || lap_latch !== 1'b1 || disp_sel !== 1'b1 || run_led !== 1'b1) begin
            failures++;
            $display("FAIL lap_enter got state=%0d latch=%b sel=%b led=%b exp 2/1/1/1",
                     state, lap_latch, disp_sel, run_led);
        end
        tick();
        checks++;
        if (lap_latch !== 1'b0) begin
            failures++;
            $display("FAIL lap_single got=%b exp=0", lap_latch);
        end
        one_sec = 1'b1;
        #1;
        checks++;
        if (cnt_en !== 1'b1) begin
            failures++;
            $display("FAIL lap_cnt_en got=%b exp=1", cnt_en);
        end
        tick();
        one_sec = 1'b0;
        release_all();
        press_hold(3'b010);
        tick();
        checks++;
        if (state !== 2'd2 || lap_latch !== 1'b1) begin
            failures++;
            $display("FAIL lap_again got state=%0d latch=%b exp 2/1", state, lap_latch);
        end
        tick();
        checks++;
        if (lap_latch !== 1'b0 || disp_sel !== 1'b1) begin
            failures++;
            $display("FAIL lap_again_single got latch=%b sel=%b exp 0/1", lap_latch, disp_sel);
        end
        release_all();
        press_hold(3'b100);
        tick();
        checks++;
        if (state !== 2'd1 || disp_sel !== 1'b0 || cnt_clr !== 1'b0) begin
            failures++;
            $display("FAIL lap_release got state=%0d sel=%b clr=%b exp 1/0/0", state, disp_sel, cnt_clr);
        end
        release_all();
    endtask

    task automatic test_priority();
        press_hold(3'b001);
        tick();
        release_all();
        press_hold(3'b101);
        tick();
        checks++;
        if (state !== 2'd0 || cnt_clr !== 1'b1) begin
            failures++;
            $display("FAIL prio_clr_start got state=%0d clr=%b exp 0/1", state, cnt_clr);
        end
        release_all();
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL prio_start_discarded got state=%0d exp=0", state);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        press_hold(3'b001);
        tick();
        release_all();
        btn_lap = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        btn_lap = 1'b0;
        tick();
        reset = 1'b0;
        checks++;
        if ({state, cnt_clr, lap_latch, disp_sel, run_led, pause_blink} !== 7'h00) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=0000000",
                     {state, cnt_clr, lap_latch, disp_sel, run_led, pause_blink});
        end
        press_hold(3'b001);
        tick();
        release_all();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (state !== 2'd1 || lap_latch !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_mid_no_lap got state=%0d latch=%b exp 1/0", state, lap_latch);
        end
        // Start held through reset counts as a fresh press after deassertion.
        btn_start = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL held_reset_early got=%0d exp=0", state);
        end
        tick();
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL held_reset_accept got=%0d exp=1", state);
        end
        release_all();
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_count_gate();
        test_blink();
        test_clear();
        test_lap();
        test_priority();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
